// File: rtl/axis_rr_output_arbiter.sv
// Packet-locked round-robin arbiter sharing one AXI-stream output port.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   s_tvalid/s_tready/s_tdata/s_tlast   REN requesting AXI-S inputs
//   m_tvalid/m_tready/m_tdata/m_tlast   shared AXI-S output
//   grant_idx        granted input, meaningful while busy = 1
//   busy             1 while a packet holds the lock
//   err_ovl          one-cycle pulse when an overlength packet is cut
module axis_rr_output_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int REN        = 5,
   parameter int MAX_BEATS  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [REN-1:0]            s_tvalid,
   output logic [REN-1:0]            s_tready,
   input  logic [REN*DATA_WIDTH-1:0] s_tdata,
   input  logic [REN-1:0]            s_tlast,
   output logic                      m_tvalid,
   input  logic                      m_tready,
   output logic [DATA_WIDTH-1:0]     m_tdata,
   output logic                      m_tlast,
   output logic [$clog2(REN)-1:0]    grant_idx,
   output logic                      busy,
   output logic                      err_ovl
);

   localparam int GW = $clog2(REN);
   localparam int BW = $clog2(MAX_BEATS);
   localparam logic [BW-1:0] CNT_LAST = BW'(MAX_BEATS - 1);
   localparam logic [GW-1:0] G_LAST   = GW'(REN - 1);

   typedef enum logic {
      IDLE,
      LOCKED
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [GW-1:0]         ptr;
   logic [GW-1:0]         pick;
   logic                  pick_vld;
   int                    rr_idx;
   logic [BW-1:0]         beat_cnt;
   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  last_beat;
   logic                  xfer;
   logic                  forced;

   // Route the granted input's signals onto internal selects.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < REN; i++) begin
         if (grant_idx == GW'(i)) begin
            sel_valid = s_tvalid[i];
            sel_last  = s_tlast[i];
            sel_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Search ptr, ptr+1, ... wrapping; first requester found wins.
   always_comb begin
      pick     = ptr;
      pick_vld = 1'b0;
      rr_idx   = 0;
      for (int k = 0; k < REN; k++) begin
         rr_idx = int'(ptr) + k;
         if (rr_idx >= REN) begin
            rr_idx = rr_idx - REN;
         end
         if (!pick_vld && s_tvalid[rr_idx]) begin
            pick     = GW'(rr_idx);
            pick_vld = 1'b1;
         end
      end
   end

   // The beat counter caps the packet so a lost tlast cannot hold the port.
   assign last_beat = sel_last | (beat_cnt == CNT_LAST);
   assign xfer      = (state == LOCKED) & sel_valid & m_tready;
   assign forced    = xfer & last_beat & ~sel_last;

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      m_tvalid  = 1'b0;
      m_tdata   = '0;
      m_tlast   = 1'b0;
      s_tready  = '0;
      unique case (state)
         IDLE: begin
            if (pick_vld) begin
               state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            busy     = 1'b1;
            m_tvalid = sel_valid;
            m_tdata  = sel_data;
            m_tlast  = last_beat;
            for (int i = 0; i < REN; i++) begin
               if (grant_idx == GW'(i)) begin
                  s_tready[i] = m_tready;
               end
            end
            if (xfer && last_beat) begin
               state_nxt = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         grant_idx <= '0;
         beat_cnt  <= '0;
         err_ovl   <= 1'b0;
      end else begin
         state   <= state_nxt;
         err_ovl <= forced;
         if (state == IDLE && pick_vld) begin
            grant_idx <= pick;
            beat_cnt  <= '0;
         end
         if (xfer) begin
            if (last_beat) begin
               ptr <= (grant_idx == G_LAST) ? '0 : grant_idx + 1'b1;
            end else begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_axis_rr_output_arbiter.sv
// Self-checking bench for axis_rr_output_arbiter.
// Directed scenarios plus randomized traffic against a cycle model.
module tb_axis_rr_output_arbiter;

   localparam int DW  = 32;
   localparam int REN = 5;
   localparam int MB  = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [REN-1:0]    s_tvalid;
   logic [REN-1:0]    s_tready;
   logic [REN*DW-1:0] s_tdata;
   logic [REN-1:0]    s_tlast;
   logic              m_tvalid;
   logic              m_tready;
   logic [DW-1:0]     m_tdata;
   logic              m_tlast;
   logic [2:0]        grant_idx;
   logic              busy;
   logic              err_ovl;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit md_busy = 0;
   int md_g    = 0;
   int md_cnt  = 0;
   int md_ptr  = 0;
   bit md_err  = 0;

   axis_rr_output_arbiter #(
      .DATA_WIDTH(DW),
      .REN(REN),
      .MAX_BEATS(MB)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .s_tvalid(s_tvalid),
      .s_tready(s_tready),
      .s_tdata(s_tdata),
      .s_tlast(s_tlast),
      .m_tvalid(m_tvalid),
      .m_tready(m_tready),
      .m_tdata(m_tdata),
      .m_tlast(m_tlast),
      .grant_idx(grant_idx),
      .busy(busy),
      .err_ovl(err_ovl)
   );

   always #5 clk = ~clk;

   // Advance the model by one clock edge using the sampled inputs.
   task automatic model_clock();
      bit x;
      bit l;
      bit found;
      int idx;
      if (!rst_n) begin
         md_busy = 0;
         md_g    = 0;
         md_cnt  = 0;
         md_ptr  = 0;
         md_err  = 0;
      end else if (!md_busy) begin
         md_err = 0;
         found  = 0;
         for (int k = 0; k < REN; k++) begin
            idx = (md_ptr + k) % REN;
            if (!found && s_tvalid[idx]) begin
               found  = 1;
               md_g   = idx;
               md_cnt = 0;
            end
         end
         md_busy = found;
      end else begin
         x = s_tvalid[md_g] && m_tready;
         l = s_tlast[md_g] || (md_cnt == MB - 1);
         md_err = x && l && !s_tlast[md_g];
         if (x) begin
            if (l) begin
               md_busy = 0;
               md_ptr  = (md_g + 1) % REN;
            end else begin
               md_cnt = md_cnt + 1;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic set_in(input int i, input logic v,
                         input logic [DW-1:0] d, input logic l);
      s_tvalid[i]         = v;
      s_tdata[i*DW +: DW] = d;
      s_tlast[i]          = l;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      s_tvalid = '1;
      s_tlast  = '0;
      s_tdata  = '0;
      m_tready = 1'b1;
      tick();
      tick();
      settle();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got %b exp 0", busy);
      end
      checks++;
      if (m_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_m_tvalid got %b exp 0", m_tvalid);
      end
      checks++;
      if (s_tready !== 5'b0) begin
         errors++;
         $display("FAIL reset_s_tready got %b exp 00000", s_tready);
      end
      checks++;
      if (err_ovl !== 1'b0) begin
         errors++;
         $display("FAIL reset_err_ovl got %b exp 0", err_ovl);
      end
      checks++;
      if (grant_idx !== 3'd0) begin
         errors++;
         $display("FAIL reset_grant got %0d exp 0", grant_idx);
      end
      checks++;
      if (m_tlast !== 1'b0) begin
         errors++;
         $display("FAIL reset_m_tlast got %b exp 0", m_tlast);
      end
      s_tvalid = '0;
   endtask

   task automatic test_single_packet();
      logic [DW-1:0] d;
      rst_n = 1'b1;
      set_in(2, 1'b1, 32'h2000_0000, 1'b0);
      settle();
      checks++;
      if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL pkt_bubble got busy=%b vld=%b exp 0 0",
                  busy, m_tvalid);
      end
      tick();
      for (int b = 0; b < 3; b++) begin
         d = 32'h2000_0000 + 32'(b);
         set_in(2, 1'b1, d, b == 2);
         settle();
         checks++;
         if (busy !== 1'b1 || grant_idx !== 3'd2) begin
            errors++;
            $display("FAIL pkt_grant b%0d got %b/%0d exp 1/2",
                     b, busy, grant_idx);
         end
         checks++;
         if (m_tvalid !== 1'b1 || m_tdata !== d) begin
            errors++;
            $display("FAIL pkt_data b%0d got %b/%h exp 1/%h",
                     b, m_tvalid, m_tdata, d);
         end
         checks++;
         if (m_tlast !== (b == 2)) begin
            errors++;
            $display("FAIL pkt_tlast b%0d got %b exp %b",
                     b, m_tlast, b == 2);
         end
         checks++;
         if (s_tready !== 5'b00100) begin
            errors++;
            $display("FAIL pkt_ready b%0d got %b exp 00100",
                     b, s_tready);
         end
         tick();
      end
      set_in(2, 1'b0, '0, 1'b0);
      settle();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL pkt_release got %b exp 0", busy);
      end
   endtask

   task automatic test_rr_order();
      int ord[6] = '{3, 4, 0, 1, 2, 3};
      logic [REN-1:0] er;
      for (int i = 0; i < REN; i++) begin
         set_in(i, 1'b1, 32'h0000_00C0 + 32'(i), 1'b1);
      end
      for (int n = 0; n < 6; n++) begin
         settle();
         checks++;
         if (busy !== 1'b0 || s_tready !== 5'b0) begin
            errors++;
            $display("FAIL rr_bubble n%0d got %b/%b exp 0/00000",
                     n, busy, s_tready);
         end
         tick();
         settle();
         er = 5'(1 << ord[n]);
         checks++;
         if (busy !== 1'b1 || grant_idx !== 3'(ord[n])) begin
            errors++;
            $display("FAIL rr_grant n%0d got %b/%0d exp 1/%0d",
                     n, busy, grant_idx, ord[n]);
         end
         checks++;
         if (m_tdata !== 32'h0000_00C0 + 32'(ord[n]) || m_tlast !== 1'b1) begin
            errors++;
            $display("FAIL rr_data n%0d got %h/%b exp %h/1",
                     n, m_tdata, m_tlast, 32'h0000_00C0 + 32'(ord[n]));
         end
         checks++;
         if (s_tready !== er) begin
            errors++;
            $display("FAIL rr_ready n%0d got %b exp %b", n, s_tready, er);
         end
         tick();
      end
      s_tvalid = '0;
      s_tlast  = '0;
   endtask

   task automatic test_backpressure();
      set_in(1, 1'b1, 32'h100, 1'b0);
      tick();
      settle();
      checks++;
      if (grant_idx !== 3'd1 || s_tready !== 5'b00010) begin
         errors++;
         $display("FAIL bp_first got %0d/%b exp 1/00010",
                  grant_idx, s_tready);
      end
      tick();
      set_in(1, 1'b1, 32'h101, 1'b0);
      m_tready = 1'b0;
      for (int j = 0; j < 4; j++) begin
         s_tvalid[0] = j[0];
         s_tvalid[4] = ~j[0];
         settle();
         checks++;
         if (m_tdata !== 32'h101 || m_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold j%0d got %h/%b exp 00000101/1",
                     j, m_tdata, m_tvalid);
         end
         checks++;
         if (s_tready !== 5'b0 || grant_idx !== 3'd1 || m_tlast !== 1'b0) begin
            errors++;
            $display("FAIL bp_mask j%0d got %b/%0d/%b exp 00000/1/0",
                     j, s_tready, grant_idx, m_tlast);
         end
         tick();
      end
      s_tvalid[0] = 1'b0;
      s_tvalid[4] = 1'b0;
      m_tready    = 1'b1;
      settle();
      checks++;
      if (s_tready !== 5'b00010 || m_tdata !== 32'h101) begin
         errors++;
         $display("FAIL bp_resume got %b/%h exp 00010/00000101",
                  s_tready, m_tdata);
      end
      tick();
      set_in(1, 1'b1, 32'h102, 1'b1);
      settle();
      checks++;
      if (m_tlast !== 1'b1 || m_tdata !== 32'h102) begin
         errors++;
         $display("FAIL bp_last got %b/%h exp 1/00000102", m_tlast, m_tdata);
      end
      tick();
      set_in(1, 1'b0, '0, 1'b0);
      settle();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_release got %b exp 0", busy);
      end
   endtask

   task automatic test_overlength();
      logic [DW-1:0] d;
      set_in(4, 1'b1, 32'h401, 1'b0);
      tick();
      for (int b = 1; b <= 16; b++) begin
         d = 32'h400 + 32'(b);
         set_in(4, 1'b1, d, 1'b0);
         settle();
         checks++;
         if (grant_idx !== 3'd4 || m_tdata !== d) begin
            errors++;
            $display("FAIL ovl_beat b%0d got %0d/%h exp 4/%h",
                     b, grant_idx, m_tdata, d);
         end
         checks++;
         if (m_tlast !== (b == 16) || err_ovl !== 1'b0) begin
            errors++;
            $display("FAIL ovl_tlast b%0d got %b/%b exp %b/0",
                     b, m_tlast, err_ovl, b == 16);
         end
         tick();
      end
      set_in(4, 1'b1, 32'h411, 1'b0);
      set_in(0, 1'b1, 32'hA0, 1'b1);
      settle();
      checks++;
      if (err_ovl !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ovl_pulse got %b/%b exp 1/0", err_ovl, busy);
      end
      tick();
      settle();
      checks++;
      if (grant_idx !== 3'd0 || err_ovl !== 1'b0 || m_tdata !== 32'hA0) begin
         errors++;
         $display("FAIL ovl_ptr got %0d/%b/%h exp 0/0/000000a0",
                  grant_idx, err_ovl, m_tdata);
      end
      tick();
      set_in(0, 1'b0, '0, 1'b0);
      tick();
      for (int b = 17; b <= 20; b++) begin
         d = 32'h400 + 32'(b);
         set_in(4, 1'b1, d, b == 20);
         settle();
         checks++;
         if (grant_idx !== 3'd4 || m_tdata !== d || m_tlast !== (b == 20)) begin
            errors++;
            $display("FAIL ovl_rest b%0d got %0d/%h/%b exp 4/%h/%b",
                     b, grant_idx, m_tdata, m_tlast, d, b == 20);
         end
         tick();
      end
      set_in(4, 1'b0, '0, 1'b0);
      settle();
      checks++;
      if (err_ovl !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ovl_clean got %b/%b exp 0/0", err_ovl, busy);
      end
   endtask

   task automatic test_mid_reset();
      set_in(1, 1'b1, 32'h111, 1'b1);
      tick();
      tick();
      set_in(1, 1'b0, '0, 1'b0);
      set_in(3, 1'b1, 32'h301, 1'b0);
      tick();
      settle();
      checks++;
      if (grant_idx !== 3'd3 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mr_grant got %0d/%b exp 3/1", grant_idx, busy);
      end
      tick();
      set_in(3, 1'b1, 32'h302, 1'b0);
      rst_n = 1'b0;
      tick();
      settle();
      checks++;
      if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL mr_drop got %b/%b exp 0/0", busy, m_tvalid);
      end
      checks++;
      if (s_tready !== 5'b0 || err_ovl !== 1'b0) begin
         errors++;
         $display("FAIL mr_ready got %b/%b exp 00000/0", s_tready, err_ovl);
      end
      rst_n = 1'b1;
      set_in(1, 1'b1, 32'h1F1, 1'b1);
      tick();
      settle();
      checks++;
      if (grant_idx !== 3'd1) begin
         errors++;
         $display("FAIL mr_ptr got %0d exp 1", grant_idx);
      end
      tick();
      set_in(1, 1'b0, '0, 1'b0);
   endtask

   task automatic test_locked_ignore();
      logic [DW-1:0] d;
      tick();
      set_in(0, 1'b1, 32'h0A, 1'b1);
      for (int b = 2; b <= 4; b++) begin
         d = 32'h300 + 32'(b);
         set_in(3, 1'b1, d, b == 4);
         settle();
         checks++;
         if (grant_idx !== 3'd3 || s_tready !== 5'b01000 || m_tdata !== d) begin
            errors++;
            $display("FAIL lk_hold b%0d got %0d/%b/%h exp 3/01000/%h",
                     b, grant_idx, s_tready, m_tdata, d);
         end
         tick();
      end
      set_in(3, 1'b0, '0, 1'b0);
      settle();
      checks++;
      if (busy !== 1'b0 || s_tready !== 5'b0) begin
         errors++;
         $display("FAIL lk_bubble got %b/%b exp 0/00000", busy, s_tready);
      end
      tick();
      settle();
      checks++;
      if (grant_idx !== 3'd0 || s_tready !== 5'b00001 || m_tdata !== 32'h0A) begin
         errors++;
         $display("FAIL lk_next got %0d/%b/%h exp 0/00001/0000000a",
                  grant_idx, s_tready, m_tdata);
      end
      tick();
      set_in(0, 1'b0, '0, 1'b0);
      tick();
   endtask

   task automatic test_random();
      logic [REN-1:0] er;
      logic [DW-1:0]  ed;
      logic           ev;
      logic           el;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < REN; i++) begin
            set_in(i, $urandom_range(0, 3) != 0, $urandom,
                   $urandom_range(0, 9) == 0);
         end
         m_tready = $urandom_range(0, 3) != 0;
         rst_n    = $urandom_range(0, 149) != 0;
         settle();
         ev = md_busy && s_tvalid[md_g];
         el = md_busy && (s_tlast[md_g] || md_cnt == MB - 1);
         er = (md_busy && m_tready) ? 5'(1 << md_g) : 5'b0;
         ed = s_tdata[md_g*DW +: DW];
         checks++;
         if (busy !== md_busy || m_tvalid !== ev || m_tlast !== el) begin
            errors++;
            $display("FAIL rnd_ctl c%0d got %b%b%b exp %b%b%b",
                     c, busy, m_tvalid, m_tlast, md_busy, ev, el);
         end
         checks++;
         if (s_tready !== er || err_ovl !== md_err) begin
            errors++;
            $display("FAIL rnd_rdy c%0d got %b/%b exp %b/%b",
                     c, s_tready, err_ovl, er, md_err);
         end
         if (md_busy) begin
            checks++;
            if (grant_idx !== 3'(md_g) || m_tdata !== ed) begin
               errors++;
               $display("FAIL rnd_dat c%0d got %0d/%h exp %0d/%h",
                        c, grant_idx, m_tdata, md_g, ed);
            end
         end
         tick();
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      s_tvalid = '0;
      s_tlast  = '0;
      s_tdata  = '0;
      m_tready = 1'b1;
      #1;
      test_reset();
      test_single_packet();
      test_rr_order();
      test_backpressure();
      test_overlength();
      test_mid_reset();
      test_locked_ignore();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
